// File: rtl/cu_ifetch_pkg.sv
// rtl/cu_ifetch_pkg.sv - shared types and constants for the CU instruction-fetch responder
// Purpose: NOP fill word, response tag type and the maximum supported SRAM read latency.
// Ports: none (package).
package cu_ifetch_pkg;

  // RISC-V "addi x0,x0,0" returned for fetches that fall outside the SRAM
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam int RD_LAT_MAX = 3;

  // One tag per granted fetch travels alongside the SRAM read
  typedef struct packed {
    logic vld;
    logic oor;
  } resp_tag_t;

endpackage

// File: rtl/cu_ifetch_responder_if.sv
// rtl/cu_ifetch_responder_if.sv - fetch, loader, SRAM and error signal bundle
// Purpose: groups every non-clock signal of the responder.
// Modports: slave  = responder view (drives gnt/ready/response/SRAM/error outputs)
//           master = environment view (core, loader and SRAM macro side)
interface cu_ifetch_responder_if #(
  parameter int ADDR_W = 19,
  parameter int MEM_AW = 10
);
  logic              fetch_req;
  logic              fetch_gnt;
  logic [ADDR_W-1:0] fetch_addr;
  logic [31:0]       fetch_r_data;
  logic              fetch_r_valid;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              mem_ce;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              err_clr;
  logic              err_oor;
  logic              err_misalign;

  modport slave (
    input  fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata, err_clr,
    output fetch_gnt, fetch_r_data, fetch_r_valid, load_ready,
           mem_ce, mem_we, mem_addr, mem_wdata, err_oor, err_misalign
  );

  modport master (
    output fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata, err_clr,
    input  fetch_gnt, fetch_r_data, fetch_r_valid, load_ready,
           mem_ce, mem_we, mem_addr, mem_wdata, err_oor, err_misalign
  );
endinterface

// File: rtl/cu_ifetch_resp_pipe.sv
// rtl/cu_ifetch_resp_pipe.sv - fixed-depth shift register of response tags
// Purpose: delays each fetch tag by DEPTH cycles so it lines up with SRAM read data.
// Ports: clk, rst_n (async active-low clear), i_tag (tag entering), o_tag (tag DEPTH cycles old).
module cu_ifetch_resp_pipe
  import cu_ifetch_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  resp_tag_t i_tag,
  output resp_tag_t o_tag
);

  resp_tag_t [DEPTH-1:0] r_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/cu_ifetch_responder.sv
// rtl/cu_ifetch_responder.sv - CU instruction-fetch responder with loader arbitration
// Purpose: grants core fetches onto a single-port instruction SRAM, returns words in
//          order RD_LAT cycles later, and shares the port with a loader write path
//          that cannot be starved for more than STARVE_MAX cycles.
// Ports: clk, rst_n (async active-low), bus (cu_ifetch_responder_if.slave):
//        fetch_* core request/response, load_* loader writes, mem_* SRAM macro,
//        err_clr / err_oor / err_misalign sticky error flags.
module cu_ifetch_responder
  import cu_ifetch_pkg::*;
#(
  parameter int          ADDR_W      = 19,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          MEM_AW      = 10,
  parameter int          RD_LAT      = 1,
  parameter int          STARVE_MAX  = 4,
  parameter logic [31:0] OOR_WORD    = NOP_WORD
) (
  input logic                  clk,
  input logic                  rst_n,
  cu_ifetch_responder_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [IDX_W-1:0] w_f_idx;
  logic [IDX_W-1:0] w_l_idx;
  logic             w_f_in;
  logic             w_l_in;
  logic             w_starved;
  logic             w_fetch_gnt;
  logic             w_load_rdy;
  logic             w_set_oor;
  logic             w_set_mis;
  logic [31:0]      w_resp_data;
  resp_tag_t        w_tag_in;
  resp_tag_t        w_tag_out;

  logic [CNT_W-1:0] r_starve;
  logic             r_err_oor;
  logic             r_err_mis;
  logic [31:0]      r_hold;

  assign w_f_idx = bus.fetch_addr[ADDR_W-1:2];
  assign w_l_idx = bus.load_addr[ADDR_W-1:2];
  assign w_f_in  = 32'(w_f_idx) < 32'(DEPTH_WORDS);
  assign w_l_in  = 32'(w_l_idx) < 32'(DEPTH_WORDS);

  // Arbitration: fetch has priority until the loader has lost STARVE_MAX times in a row.
  // Gated with rst_n so the combinational handshakes read 0 while reset is held.
  assign w_starved   = (r_starve == CNT_W'(STARVE_MAX));
  assign w_fetch_gnt = rst_n && bus.fetch_req && !(bus.load_valid && w_starved);
  assign w_load_rdy  = rst_n && bus.load_valid && !w_fetch_gnt;

  assign bus.fetch_gnt  = w_fetch_gnt;
  assign bus.load_ready = w_load_rdy;

  // Out-of-range accesses are acknowledged but never touch the SRAM
  assign bus.mem_we    = w_load_rdy && w_l_in;
  assign bus.mem_ce    = (w_fetch_gnt && w_f_in) || bus.mem_we;
  assign bus.mem_addr  = w_load_rdy ? w_l_idx[MEM_AW-1:0] : w_f_idx[MEM_AW-1:0];
  assign bus.mem_wdata = bus.load_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!bus.load_valid || w_load_rdy) begin
      r_starve <= '0;
    end else if (!w_starved) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign w_set_oor = (w_fetch_gnt && !w_f_in) || (w_load_rdy && !w_l_in);
  assign w_set_mis = w_fetch_gnt && (bus.fetch_addr[1:0] != 2'b00);

  // A new error in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_oor <= 1'b0;
      r_err_mis <= 1'b0;
    end else begin
      r_err_oor <= w_set_oor || (r_err_oor && !bus.err_clr);
      r_err_mis <= w_set_mis || (r_err_mis && !bus.err_clr);
    end
  end

  assign bus.err_oor      = r_err_oor;
  assign bus.err_misalign = r_err_mis;

  assign w_tag_in.vld = w_fetch_gnt;
  assign w_tag_in.oor = !w_f_in;

  cu_ifetch_resp_pipe #(
    .DEPTH (RD_LAT)
  ) u_resp_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign w_resp_data = w_tag_out.oor ? OOR_WORD : bus.mem_rdata;

  // Response word is forwarded straight from the SRAM and held between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_tag_out.vld) begin
      r_hold <= w_resp_data;
    end
  end

  assign bus.fetch_r_valid = w_tag_out.vld;
  assign bus.fetch_r_data  = w_tag_out.vld ? w_resp_data : r_hold;

endmodule

// File: tb/tb_cu_ifetch_responder.sv
// tb/tb_cu_ifetch_responder.sv - scoreboard bench for cu_ifetch_responder
module tb_cu_ifetch_responder;

  localparam int          ADDR_W     = 19;
  localparam int          DEPTH      = 1024;
  localparam int          MEM_AW     = 10;
  localparam int          RD_LAT     = 2;
  localparam int          STARVE_MAX = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH] = '{default: '0};
  logic [31:0] sram    [DEPTH] = '{default: '0};
  logic [31:0] rd_pipe [RD_LAT];
  logic [31:0] last_data = '0;

  // Reference model state
  int m_starve = 0;
  bit m_oor = 0;
  bit m_mis = 0;
  bit obs_gnt;
  bit obs_we;

  cu_ifetch_responder_if #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) bus ();

  cu_ifetch_responder #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH),
    .MEM_AW      (MEM_AW),
    .RD_LAT      (RD_LAT),
    .STARVE_MAX  (STARVE_MAX),
    .OOR_WORD    (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port read-first SRAM macro with RD_LAT cycles of read latency
  always @(posedge clk) begin
    if (bus.mem_ce && !bus.mem_we) rd_pipe[0] <= sram[bus.mem_addr];
    else                           rd_pipe[0] <= $urandom;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (bus.mem_ce && bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_data = '0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("resp_missing_due_cycle", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (bus.fetch_r_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_r_valid", bus.fetch_r_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("r_data", bus.fetch_r_data, e.data);
          chk("r_latency", cyc, e.due);
        end
        last_data = bus.fetch_r_data;
      end else begin
        chk("r_data_hold", bus.fetch_r_data, last_data);
      end
    end
  end

  // One bus cycle: drive, check handshakes/SRAM port at negedge, advance the model
  task automatic cycle(input bit fr, input int fa, input bit lv, input int la,
                       input logic [31:0] ld, input bit clr);
    int fidx, lidx;
    bit fin, lin, eg, er, set_oor, set_mis;
    bus.fetch_req  = fr;
    bus.fetch_addr = ADDR_W'(fa);
    bus.load_valid = lv;
    bus.load_addr  = ADDR_W'(la);
    bus.load_data  = ld;
    bus.err_clr    = clr;
    @(negedge clk);
    fidx = (fa % (1 << ADDR_W)) / 4;
    lidx = (la % (1 << ADDR_W)) / 4;
    fin  = fidx < DEPTH;
    lin  = lidx < DEPTH;
    // Loader wins a tie only once it has been refused STARVE_MAX cycles running
    eg = fr && !(lv && m_starve >= STARVE_MAX);
    er = lv && !eg;
    obs_gnt = bus.fetch_gnt;
    obs_we  = bus.mem_we;
    chk("fetch_gnt", bus.fetch_gnt, eg);
    chk("load_ready", bus.load_ready, er);
    chk("mem_ce", bus.mem_ce, (eg && fin) || (er && lin));
    chk("mem_we", bus.mem_we, er && lin);
    if (er && lin) begin
      chk("mem_addr_wr", bus.mem_addr, lidx);
      chk("mem_wdata", bus.mem_wdata, ld);
    end else if (eg && fin) begin
      chk("mem_addr_rd", bus.mem_addr, fidx);
    end
    chk("err_oor", bus.err_oor, m_oor);
    chk("err_misalign", bus.err_misalign, m_mis);
    if (eg) exp_q.push_back('{due: cyc + RD_LAT, data: fin ? ref_mem[fidx] : NOP});
    if (er && lin) ref_mem[lidx] = ld;
    set_oor = (eg && !fin) || (er && !lin);
    set_mis = eg && (fa % 4 != 0);
    m_oor = set_oor || (m_oor && !clr);
    m_mis = set_mis || (m_mis && !clr);
    if (lv && !er) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    else           m_starve = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_fetch_gnt", bus.fetch_gnt, 1'b0);
    chk("rst_load_ready", bus.load_ready, 1'b0);
    chk("rst_r_valid", bus.fetch_r_valid, 1'b0);
    chk("rst_r_data", bus.fetch_r_data, 32'h0);
    chk("rst_mem_ce", bus.mem_ce, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_err_oor", bus.err_oor, 1'b0);
    chk("rst_err_misalign", bus.err_misalign, 1'b0);
  endtask

  initial begin
    logic [7:0] pat;
    int         nwr;
    rst_n = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = '0;
    bus.load_valid = 1'b1;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.err_clr    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Preload words 0..7 then fetch them back-to-back
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, i * 4, 32'hA000_0000 + i, 0);
    for (int i = 0; i < 8; i++) cycle(1, i * 4, 0, 0, 32'h0, 0);
    idle(3);

    // Out-of-range fetch returns NOP, no SRAM access, sticky err_oor
    cycle(1, 32'h1000, 0, 0, 32'h0, 0);
    idle(3);
    chk("err_oor_sticky", bus.err_oor, 1'b1);
    cycle(0, 0, 0, 0, 32'h0, 1);
    chk("err_oor_cleared", bus.err_oor, 1'b0);

    // Contention: fetch wins four times, loader wins the fifth, then fetch again
    nwr = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 32'h20 + i * 4, 1, 32'h40, 32'h5555_0000 + i, 0);
      pat[i] = obs_gnt;
      nwr += int'(obs_we);
    end
    chk("contention_gnt_pattern", pat, 8'b1110_1111);
    chk("contention_one_write", nwr, 1);
    idle(3);

    // Misaligned fetch and err_clr interplay
    cycle(0, 0, 1, 32'h4, 32'hDEAD_BEEF, 0);
    cycle(1, 32'h6, 0, 0, 32'h0, 0);
    chk("err_misalign_set", bus.err_misalign, 1'b1);
    cycle(0, 0, 0, 0, 32'h0, 1);
    chk("err_misalign_clr", bus.err_misalign, 1'b0);
    cycle(1, 32'h6, 0, 0, 32'h0, 1);
    chk("err_misalign_set_wins", bus.err_misalign, 1'b1);
    idle(3);

    // Read-first hazard on word 5
    cycle(1, 32'h14, 0, 0, 32'h0, 0);
    cycle(0, 0, 1, 32'h14, 32'h0BAD_F00D, 0);
    cycle(1, 32'h14, 0, 0, 32'h0, 0);
    idle(3);

    // Out-of-range load is accepted but dropped
    cycle(0, 0, 1, 32'h7_FFFC, 32'h1234_5678, 1);
    chk("err_oor_load", bus.err_oor, 1'b1);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int fa, la;
      fa = ($urandom_range(0, 9) == 0) ? (DEPTH + $urandom_range(0, 200)) * 4
                                       : $urandom_range(0, 15) * 4;
      if ($urandom_range(0, 7) == 0) fa += $urandom_range(1, 3);
      la = ($urandom_range(0, 11) == 0) ? (DEPTH + $urandom_range(0, 200)) * 4
                                        : $urandom_range(0, 15) * 4;
      cycle($urandom_range(0, 3) != 0, fa, $urandom_range(0, 2) == 0, la,
            $urandom, $urandom_range(0, 15) == 0);
    end
    idle(4);

    // Reset with responses in flight: they must be dropped
    cycle(1, 32'h0, 0, 0, 32'h0, 0);
    cycle(1, 32'h4, 0, 0, 32'h0, 0);
    cycle(1, 32'h1000, 0, 0, 32'h0, 0);
    rst_n = 1'b0;
    exp_q.delete();
    m_starve = 0;
    m_oor = 0;
    m_mis = 0;
    bus.fetch_req  = 1'b1;
    bus.load_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cu_ifetch_responder.md
Name: cu_ifetch_responder

Overview:
- Responder end of the CU instruction-fetch interface. Accepts core fetch requests, reads a single-port instruction SRAM, and returns 32-bit instruction words in order with fixed latency.
- Also arbitrates a host/DMA loader write port onto the same SRAM, with starvation protection.
- Sits between the CU core and its private instruction memory macro.

Parameters:
- ADDR_W, 19, byte-address width of fetch/load addresses.
- DEPTH_WORDS, 1024, instruction SRAM depth in 32-bit words.
- MEM_AW, 10, SRAM word-address width; must equal clog2(DEPTH_WORDS).
- RD_LAT, 1, SRAM read latency in cycles; legal values 1..3.
- STARVE_MAX, 4, consecutive cycles a loader request may lose arbitration before it wins.
- OOR_WORD, 32'h0000_0013, word returned for out-of-range fetches (NOP encoding).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  core fetch request.
- fetch_gnt  out  1  request accepted this cycle.
- fetch_addr  in  ADDR_W  byte address of the fetch.
- fetch_r_data  out  32  returned instruction word.
- fetch_r_valid  out  1  fetch_r_data valid; one pulse per grant, in order.
- load_valid  in  1  loader write request.
- load_ready  out  1  loader write accepted this cycle.
- load_addr  in  ADDR_W  loader byte address.
- load_data  in  32  loader write data.
- mem_ce  out  1  SRAM chip enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid RD_LAT cycles after a read ce.
- err_clr  in  1  clears sticky error flags.
- err_oor  out  1  sticky: out-of-range fetch or load seen.
- err_misalign  out  1  sticky: fetch with addr[1:0]!=0 seen.

Behaviour:
- Reset values: fetch_gnt=0, fetch_r_valid=0, fetch_r_data=0, load_ready=0, mem_ce=0, mem_we=0, err flags=0, starve counter=0, response pipe valids=0.
- Word index = addr[ADDR_W-1:2]. An address is in range iff word index < DEPTH_WORDS.
- Arbitration is combinational in the request cycle. At most one SRAM access per cycle.
  - fetch_req only: fetch_gnt=1.
  - load_valid only: load_ready=1.
  - Both asserted: fetch wins, unless the starve counter == STARVE_MAX, in which case load wins.
- Starve counter:
  - Increments each cycle load_valid=1 and load_ready=0.
  - Resets to 0 on load_ready, or when load_valid=0.
  - Saturates at STARVE_MAX.
- Granted fetch, in range: mem_ce=1, mem_we=0, mem_addr=word index in the grant cycle. fetch_r_valid=1 exactly RD_LAT cycles later, with fetch_r_data=mem_rdata.
- Granted fetch, out of range: mem_ce=0. The response still appears RD_LAT cycles later with fetch_r_data=OOR_WORD, and err_oor sets.
- Misaligned fetch: the aligned word is returned and err_misalign sets.
- Accepted load, in range: mem_ce=1, mem_we=1, mem_addr=word index, mem_wdata=load_data.
- Accepted load, out of range: the write is dropped (mem_ce=0), load_ready is still 1, and err_oor sets.
- Back-to-back grants every cycle are legal, and there is no outstanding limit. Responses are in order with fixed latency; the core has no backpressure on the response path.
- fetch_r_data holds its last value when fetch_r_valid=0.
- Response tracking: a shift pipe of depth RD_LAT carrying {valid, oor}.
- Load-after-fetch hazard to the same word: the fetch returns the old data (SRAM read-first ordering).
- err_clr and an error set in the same cycle: set wins.
- Reset mid-operation: the pipe is cleared and in-flight responses are dropped; no fetch_r_valid appears after reset deasserts for pre-reset grants.

Decomposition:
- Shared package cu_ifetch_pkg holds:
  - the NOP constant for OOR_WORD;
  - typedef resp_tag_t {logic vld; logic oor;};
  - localparam RD_LAT_MAX=3.
- One sub-module, cu_ifetch_resp_pipe: a parameterised RD_LAT-deep shift register of resp_tag_t with asynchronous clear.

Test Plan:
- Preload words 0..7 via the loader (data=32'hA000_0000+i), then fetch addresses 0x0,0x4,...,0x1C on consecutive cycles -> 8 gnts and 8 r_valid pulses RD_LAT cycles later, data A000_0000..A000_0007 in order.
- Fetch addr 19'h1000 (word 1024, DEPTH 1024) -> fetch_gnt=1, mem_ce=0, r_data=32'h0000_0013 after RD_LAT, err_oor=1 until err_clr.
- Hold fetch_req and load_valid high together for 8 cycles -> fetches granted cycles 0-3, load_ready in cycle 4, fetch granted again from cycle 5; exactly one load write.
- Fetch addr 0x6 with word 1 = 32'hDEAD_BEEF -> r_data=DEAD_BEEF, err_misalign=1. Pulse err_clr -> 0. err_clr concurrent with a new misaligned fetch -> stays 1.
- Grant 3 back-to-back fetches with RD_LAT=2, assert rst_n=0 one cycle after the last grant -> no r_valid ever observed for them; all outputs at reset values.
- Load to word 5 in the cycle after a fetch of word 5 -> fetch returns old value, a subsequent fetch returns the new value.
